wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline write-back stage and a multi-cycle unit (mult/div).
//  The pipeline write-back value (the WB mux output) normally has priority.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_result_fifo.sv | 68 ++++++
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // Winner of the write port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_PIPE  = 2'd1,
        GNT_MC    = 2'd2,
        GNT_FORCE = 2'd3
    } gnt_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding {addr,data} multi-cycle results.
// The head is read straight from storage, so a pushed entry becomes
// visible only in the cycle after the push (no fall-through).
module wb_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    // Guard against overflow/underflow even if the caller misbehaves
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state; depth is a power of two so pointers wrap
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; cleared asynchronously so reset empties the buffer at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back and
// buffered multi-cycle results. Pipeline wins unless a buffered result
// has been passed over STARVE_MAX times, in which case the pipeline is
// stalled for one slot.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RegWrite,
    input  logic [ADDR_W-1:0]             writeReg,
    input  logic [DATA_W-1:0]             outMuxWb,
    input  logic                          mcValid,
    output logic                          mcReady,
    input  logic [ADDR_W-1:0]             mcReg,
    input  logic [DATA_W-1:0]             mcData,
    output logic                          stallPipe,
    output logic                          rfWe,
    output logic [ADDR_W-1:0]             rfAddr,
    output logic [DATA_W-1:0]             rfData,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    gnt_e              gnt;
    logic              pipe_req;
    logic              fifo_full, fifo_empty;
    logic              mc_push, mc_pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    // Register 0 is hardwired; such writes are swallowed on both sides
    assign pipe_req = RegWrite && (writeReg != '0);
    // Ready comes from registered occupancy only: a full FIFO refuses even while popping
    assign mcReady  = !fifo_full;
    assign mc_push  = mcValid && mcReady && (mcReg != '0);

    wb_result_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mc_push),
        .pop   (mc_pop),
        .din   ({mcReg, mcData}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifoCount),
        .head  ({head_addr, head_data})
    );

    // Port grant: forced MC slot, then pipeline, then idle-slot drain
    always_comb begin
        gnt = GNT_NONE;
        if (pipe_req && !fifo_empty && (starve_q == STARVE_LIM)) gnt = GNT_FORCE;
        else if (pipe_req)                                     gnt = GNT_PIPE;
        else if (!fifo_empty)                                  gnt = GNT_MC;
    end

    assign stallPipe = (gnt == GNT_FORCE);
    assign mc_pop    = (gnt == GNT_MC) || (gnt == GNT_FORCE);

    // Starvation count: pipeline wins over a waiting entry, reset by any pop
    always_comb begin
        starve_d = starve_q;
        if (mc_pop)
            starve_d = '0;
        else if ((gnt == GNT_PIPE) && !fifo_empty && (starve_q != STARVE_LIM))
            starve_d = starve_q + 1'b1;
    end

    // Write-port next values; address/data hold when idle to avoid toggling
    always_comb begin
        rf_we_d   = (gnt != GNT_NONE);
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (gnt == GNT_PIPE) begin
            rf_addr_d = writeReg;
            rf_data_d = outMuxWb;
        end else if (mc_pop) begin
            rf_addr_d = head_addr;
            rf_data_d = head_data;
        end
    end

    // Registered write port and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rfWe   = rf_we_q;
    assign rfAddr = rf_addr_q;
    assign rfData = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios for the write-port arbiter. Expected register-file
// writes (address, data, cycle) are queued when stimulus is driven and
// matched against rfWe/rfAddr/rfData on the falling edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] outMuxWb;
    logic        mcValid;
    logic        mcReady;
    logic [4:0]  mcReg;
    logic [31:0] mcData;
    logic        stallPipe;
    logic        rfWe;
    logic [4:0]  rfAddr;
    logic [31:0] rfData;
    logic [1:0]  fifoCount;

    wb_port_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (2),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .writeReg  (writeReg),
        .outMuxWb  (outMuxWb),
        .mcValid   (mcValid),
        .mcReady   (mcReady),
        .mcReg     (mcReg),
        .mcData    (mcData),
        .stallPipe (stallPipe),
        .rfWe      (rfWe),
        .rfAddr    (rfAddr),
        .rfData    (rfData),
        .fifoCount (fifoCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int at);
        exp_t e;
        e.cyc  = at;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs, then let them settle
    task automatic drv(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
        RegWrite = rw;
        writeReg = wr;
        outMuxWb = wd;
        mcValid  = mv;
        mcReg    = mr;
        mcData   = md;
        #1;
    endtask

    // Compare the write port against the scoreboard head
    task automatic monitor();
        exp_t e;
        if (rfWe) begin
            if (sb.size() == 0) begin
                chk("spurious_we", {59'd0, rfAddr}, 64'h3f);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {59'd0, rfAddr}, {59'd0, e.addr});
                chk("wr_data", {32'd0, rfData}, {32'd0, e.data});
                chk("wr_cyc", 64'(cyc), 64'(e.cyc));
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missing_we", {59'd0, e.addr}, 64'h3f);
        end
    endtask

    task automatic tick(input logic exp_stall = 1'b0);
        @(negedge clk);
        chk("stallPipe", {63'd0, stallPipe}, {63'd0, exp_stall});
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rfWe",   {63'd0, rfWe}, 64'd0);
        chk("rst_rfAddr", {59'd0, rfAddr}, 64'd0);
        chk("rst_rfData", {32'd0, rfData}, 64'd0);
        chk("rst_count",  {62'd0, fifoCount}, 64'd0);
        chk("rst_ready",  {63'd0, mcReady}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: pipeline only
        drv(1, 3, 32'hDEADBEEF, 0, 0, 0);
        expect_wr(3, 32'hDEADBEEF, cyc + 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // 2: idle drain, write lands two cycles after the handshake
        drv(0, 0, 0, 1, 7, 32'h10);
        chk("t2_ready", {63'd0, mcReady}, 64'd1);
        expect_wr(7, 32'h10, cyc + 2);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        chk("t2_count1", {62'd0, fifoCount}, 64'd1);
        tick();
        chk("t2_count0", {62'd0, fifoCount}, 64'd0);
        tick();

        // 3: starvation, 4 pipeline wins then a forced MC slot
        drv(0, 0, 0, 1, 20, 32'hA5);
        tick();
        begin
            int r = 1;
            for (int c = 0; c < 10; c++) begin
                logic st;
                st = (c == 4);
                drv(1, 5'(r), 32'h100 + r, 0, 0, 0);
                if (st) begin
                    expect_wr(20, 32'hA5, cyc + 1);
                end else begin
                    expect_wr(5'(r), 32'h100 + r, cyc + 1);
                    r++;
                end
                tick(st);
            end
        end
        drv(0, 0, 0, 0, 0, 0);
        chk("t3_count0", {62'd0, fifoCount}, 64'd0);
        tick();
        tick();

        // 4: full FIFO under pipeline writes, third result held until a pop
        drv(1, 11, 32'h20B, 1, 21, 32'hB1);
        chk("t4_rdy_a", {63'd0, mcReady}, 64'd1);
        expect_wr(11, 32'h20B, cyc + 1);
        tick();
        drv(1, 12, 32'h20C, 1, 22, 32'hB2);
        chk("t4_rdy_b", {63'd0, mcReady}, 64'd1);
        chk("t4_cnt_b", {62'd0, fifoCount}, 64'd1);
        expect_wr(12, 32'h20C, cyc + 1);
        tick();
        drv(1, 13, 32'h20D, 1, 23, 32'hB3);
        chk("t4_rdy_full", {63'd0, mcReady}, 64'd0);
        chk("t4_cnt_full", {62'd0, fifoCount}, 64'd2);
        expect_wr(13, 32'h20D, cyc + 1);
        tick();
        drv(1, 14, 32'h20E, 1, 23, 32'hB3);
        chk("t4_rdy_full2", {63'd0, mcReady}, 64'd0);
        expect_wr(14, 32'h20E, cyc + 1);
        tick();
        drv(0, 0, 0, 1, 23, 32'hB3);
        chk("t4_rdy_popping", {63'd0, mcReady}, 64'd0);
        expect_wr(21, 32'hB1, cyc + 1);
        tick();
        drv(0, 0, 0, 1, 23, 32'hB3);
        chk("t4_rdy_after_pop", {63'd0, mcReady}, 64'd1);
        chk("t4_cnt_after_pop", {62'd0, fifoCount}, 64'd1);
        expect_wr(22, 32'hB2, cyc + 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        chk("t4_cnt_pushpop", {62'd0, fifoCount}, 64'd1);
        expect_wr(23, 32'hB3, cyc + 1);
        tick();
        chk("t4_cnt_end", {62'd0, fifoCount}, 64'd0);
        tick();

        // 5: register 0 on both sides never reaches the port
        drv(1, 0, 32'h77, 0, 0, 0);
        tick();
        drv(0, 0, 0, 1, 0, 32'h55);
        chk("t5_ready", {63'd0, mcReady}, 64'd1);
        chk("t5_we_pipe0", {63'd0, rfWe}, 64'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        chk("t5_count", {62'd0, fifoCount}, 64'd0);
        chk("t5_we_mc0", {63'd0, rfWe}, 64'd0);
        tick();
        tick();

        // 6: reset with two results buffered and the starvation count raised
        drv(1, 2, 32'h302, 1, 24, 32'hC4);
        expect_wr(2, 32'h302, cyc + 1);
        tick();
        drv(1, 3, 32'h303, 1, 25, 32'hC5);
        expect_wr(3, 32'h303, cyc + 1);
        tick();
        drv(1, 4, 32'h304, 0, 0, 0);
        expect_wr(4, 32'h304, cyc + 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        chk("t6_cnt_pre", {62'd0, fifoCount}, 64'd2);
        @(negedge clk);
        monitor();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_cnt_rst",    {62'd0, fifoCount}, 64'd0);
        chk("t6_we_rst",     {63'd0, rfWe}, 64'd0);
        chk("t6_addr_rst",   {59'd0, rfAddr}, 64'd0);
        chk("t6_data_rst",   {32'd0, rfData}, 64'd0);
        chk("t6_starve_rst", 64'(dut.starve_q), 64'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        repeat (4) tick();
        chk("t6_cnt_post", {62'd0, fifoCount}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
